// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver with scan-code FIFO
//
// Purpose:
//   Synchronises and de-glitches the raw PS/2 clock/data pins, deframes
//   11-bit keyboard frames (start, 8 data LSB first, odd parity, stop),
//   checks them and buffers good bytes in a small first-word-fall-through
//   FIFO that is drained by single-cycle read strobes.
//
// Ports:
//   clk              in   system clock, all logic on posedge
//   rst              in   asynchronous active-low reset
//   ps2_clk          in   raw PS/2 clock pin (asynchronous)
//   ps2_data         in   raw PS/2 data pin (asynchronous)
//   kbd_read_enable  in   pop strobe, one cycle per byte consumed
//   kbd_data         out  FIFO head byte, valid while kbd_ready=1
//   kbd_ready        out  FIFO non-empty
//   kbd_overflow     out  sticky: a good frame was dropped on a full FIFO
//   frame_err        out  one-cycle pulse on framing/parity error or timeout

module ps2_kbd_rx #(
    parameter int DEPTH_LOG2     = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       kbd_read_enable,
    output logic [7:0] kbd_data,
    output logic       kbd_ready,
    output logic       kbd_overflow,
    output logic       frame_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0]         FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0]         FILT_ONE  = FW'(1);
    localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]         TO_ONE    = TW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    // Synchronisers preset to 1 so the bus looks idle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock follows the synchronised clock only after
    // FILTER_LEN consecutive samples disagree with it; any sample that
    // agrees restarts the run, so short glitches never get through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FILT_ONE;
        end
    end

    // Strobe is high in the cycle whose closing edge flips the filtered
    // clock from 1 to 0; data is taken from r_dat_s2 in that same cycle.
    assign w_fall = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FILT_LAST);

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_frame_err;
    logic          w_push;

    // A good frame is pushed straight from the stop-bit strobe so the byte
    // is visible the cycle after that strobe.
    assign w_push = (r_state == S_STOP) && w_fall && r_dat_s2 &&
                    (^{r_shift, r_parity});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (w_fall || r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_ONE;
            end

            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= S_SHIFT;
                            r_bit_cnt <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_push) begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE && r_to_cnt == TO_LAST) begin
                // Keyboard went quiet mid-frame: abandon the partial byte.
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
                r_to_cnt    <= '0;
            end
        end
    end

    assign frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_rd_en;
    logic                  w_wr_en;

    assign w_full  = (r_count == CNT_FULL);
    assign w_rd_en = kbd_read_enable && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en = w_push && (!w_full || w_rd_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            // Overflow is checked first so it wins over a clearing pop.
            if (w_push && !w_wr_en) begin
                r_overflow <= 1'b1;
            end else if (w_rd_en) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign kbd_data     = r_mem[r_rd_ptr];
    assign kbd_ready    = (r_count != '0);
    assign kbd_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - scoreboard bench for ps2_kbd_rx

module tb_ps2_kbd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kbd_read_enable = 1'b0;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       frame_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_err_pulses = 0;
    int         e0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_kbd_rx dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .kbd_read_enable (kbd_read_enable),
        .kbd_data        (kbd_data),
        .kbd_ready       (kbd_ready),
        .kbd_overflow    (kbd_overflow),
        .frame_err       (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts frame_err pulses and checks every byte actually popped.
    always @(negedge clk) begin
        if (rst && frame_err) n_err_pulses++;
        if (rst && kbd_read_enable && kbd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no byte", kbd_data);
            end else begin
                chk("pop_data", {24'h0, kbd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        kbd_read_enable = 1'b1;
        wait_cyc(1);
        kbd_read_enable = 1'b0;
        wait_cyc(1);
    endtask

    // mode 0: plain; 1: check push latency on stop bit; 2: pop on push cycle.
    // Push lands on the 6th posedge after ps2_clk falls (2 sync + 4 filter).
    task automatic send_frame(input logic [7:0] d, input logic par, input int nbits, input int mode);
        logic [10:0] f;
        f = {1'b1, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(8);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                wait_cyc(5);
                chk("ready_before_push", {31'h0, kbd_ready}, 32'h0);
                wait_cyc(1);
                chk("ready_after_push", {31'h0, kbd_ready}, 32'h1);
                chk("data_after_push", {24'h0, kbd_data}, {24'h0, d});
                wait_cyc(2);
            end else if (i == 10 && mode == 2) begin
                wait_cyc(5);
                kbd_read_enable = 1'b1;
                wait_cyc(1);
                kbd_read_enable = 1'b0;
                wait_cyc(2);
            end else begin
                wait_cyc(8);
            end
            ps2_clk = 1'b1;
        end
        wait_cyc(8);
        ps2_data = 1'b1;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        wait_cyc(3);
        chk("rst_ready", {31'h0, kbd_ready}, 32'h0);
        chk("rst_data", {24'h0, kbd_data}, 32'h0);
        chk("rst_overflow", {31'h0, kbd_overflow}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b1;
        wait_cyc(2);

        // 1. Reset mid-frame
        send_frame(8'h1C, 1'b0, 5, 0);
        rst = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(2);
        chk("midrst_ready", {31'h0, kbd_ready}, 32'h0);
        chk("midrst_overflow", {31'h0, kbd_overflow}, 32'h0);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 11, 0);
        chk("midrst_rx_ready", {31'h0, kbd_ready}, 32'h1);
        pop_one();

        // 2. Single good frame, latency, pop, pop on empty
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 11, 1);
        pop_one();
        chk("single_ready_after_pop", {31'h0, kbd_ready}, 32'h0);
        pop_one();
        chk("empty_pop_ready", {31'h0, kbd_ready}, 32'h0);
        chk("empty_pop_overflow", {31'h0, kbd_overflow}, 32'h0);

        // 3. Parity error then good frame
        e0 = n_err_pulses;
        send_frame(8'hF0, 1'b0, 11, 0);
        chk("parity_err_pulses", n_err_pulses - e0, 32'd1);
        chk("parity_err_ready", {31'h0, kbd_ready}, 32'h0);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 11, 0);
        chk("parity_good_ready", {31'h0, kbd_ready}, 32'h1);
        chk("parity_good_no_err", n_err_pulses - e0, 32'd1);
        pop_one();

        // 4. FIFO fill and overflow
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'(i);
            if (i <= 8) exp_q.push_back(b);
            send_frame(b, ~^b, 11, 0);
        end
        chk("ovf_set", {31'h0, kbd_overflow}, 32'h1);
        chk("ovf_ready", {31'h0, kbd_ready}, 32'h1);
        pop_one();
        chk("ovf_clear_first_pop", {31'h0, kbd_overflow}, 32'h0);
        repeat (6) pop_one();
        chk("ovf_ready_before_last", {31'h0, kbd_ready}, 32'h1);
        pop_one();
        chk("ovf_ready_after_8", {31'h0, kbd_ready}, 32'h0);

        // 5. Push and pop on the same cycle while full
        for (int i = 16; i < 24; i++) begin
            logic [7:0] b;
            b = 8'(i);
            exp_q.push_back(b);
            send_frame(b, ~^b, 11, (i == 23) ? 0 : 0);
        end
        chk("full_ready", {31'h0, kbd_ready}, 32'h1);
        exp_q.push_back(8'h18);
        send_frame(8'h18, ~^8'h18, 11, 2);
        chk("simul_no_overflow", {31'h0, kbd_overflow}, 32'h0);
        repeat (7) pop_one();
        chk("simul_count8_ready", {31'h0, kbd_ready}, 32'h1);
        pop_one();
        chk("simul_empty", {31'h0, kbd_ready}, 32'h0);

        // 6a. Glitch on ps2_clk
        e0 = n_err_pulses;
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(20);
        chk("glitch_no_err", n_err_pulses - e0, 32'd0);
        chk("glitch_ready", {31'h0, kbd_ready}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, ~^8'h5A, 11, 0);
        chk("glitch_next_no_err", n_err_pulses - e0, 32'd0);
        pop_one();

        // 6b. Timeout mid-frame
        e0 = n_err_pulses;
        send_frame(8'h33, ~^8'h33, 4, 0);
        wait_cyc(19800);
        chk("timeout_not_yet", n_err_pulses - e0, 32'd0);
        wait_cyc(400);
        chk("timeout_err", n_err_pulses - e0, 32'd1);
        chk("timeout_ready", {31'h0, kbd_ready}, 32'h0);
        exp_q.push_back(8'h29);
        send_frame(8'h29, ~^8'h29, 11, 0);
        chk("timeout_then_idle", n_err_pulses - e0, 32'd1);
        pop_one();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
